// File: rtl/flit_link_tx.sv
// Drain side of a router port FIFO: pops flits from a first-word-fall-through FIFO
// onto a credit-flow-controlled link, tracking wormhole framing and flagging errors.

module flit_link_tx #(
  parameter int WIDTH   = 18,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             link_valid,
  output logic [WIDTH-1:0] link_flit,
  input  logic             credit_in,
  output logic [CW-1:0]    credits,
  output logic             in_packet,
  output logic             err_credit,
  output logic             err_frame
);

  // Handshake: a flit moves when the FIFO is non-empty (valid) and the registered
  // credit count is non-zero (ready); fifo_read pops it and link_valid carries it
  // on the next cycle. A same-cycle credit_in never counts as ready.

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              link_valid_q, link_valid_d;
  logic [WIDTH-1:0]  link_flit_q, link_flit_d;
  logic              err_credit_q, err_credit_d;
  logic              err_frame_q, err_frame_d;
  logic              send;
  logic              frame_violation;
  logic [1:0]        flit_type;

  assign flit_type = fifo_data[WIDTH-1:WIDTH-2];
  assign send      = !rst && !fifo_empty && (credits_q != '0);
  assign fifo_read = send;

  // Framing FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM: next state, advanced only by flits actually sent
  always_comb begin
    state_d = state_q;
    if (send) begin
      case (state_q)
        ST_IDLE: begin
          if (flit_type == T_HEAD) state_d = ST_PKT;
          else                     state_d = ST_IDLE;
        end
        ST_PKT: begin
          case (flit_type)
            T_BODY:   state_d = ST_PKT;
            T_HEAD:   state_d = ST_PKT;
            T_TAIL:   state_d = ST_IDLE;
            T_SINGLE: state_d = ST_IDLE;
            default:  state_d = ST_PKT;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Framing FSM: outputs
  always_comb begin
    in_packet       = (state_q == ST_PKT);
    frame_violation = 1'b0;
    if (send) begin
      if (state_q == ST_IDLE) begin
        frame_violation = (flit_type == T_BODY) || (flit_type == T_TAIL);
      end else begin
        frame_violation = (flit_type == T_HEAD) || (flit_type == T_SINGLE);
      end
    end
  end

  // Credit counter; a return while already full saturates and raises the sticky flag
  always_comb begin
    credits_d    = credits_q;
    err_credit_d = err_credit_q;
    if (send && !credit_in) begin
      credits_d = credits_q - CW'(1);
    end else if (credit_in && !send) begin
      if (credits_q == CRED_MAX) begin
        err_credit_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_comb begin
    link_valid_d = send;
    link_flit_d  = send ? fifo_data : link_flit_q;
    err_frame_d  = err_frame_q | frame_violation;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q    <= CRED_MAX;
      link_valid_q <= 1'b0;
      link_flit_q  <= '0;
      err_credit_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      link_valid_q <= link_valid_d;
      link_flit_q  <= link_flit_d;
      err_credit_q <= err_credit_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign credits    = credits_q;
  assign link_valid = link_valid_q;
  assign link_flit  = link_flit_q;
  assign err_credit = err_credit_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_flit_link_tx.sv
// Bench for flit_link_tx: a queue-backed FIFO, a rule-level reference model with a
// flit scoreboard, a vector table for the plain packet and directed corner sequences.

module tb_flit_link_tx;

  localparam int WIDTH   = 18;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_read;
  logic             link_valid;
  logic [WIDTH-1:0] link_flit;
  logic             credit_in = 1'b0;
  logic [CW-1:0]    credits;
  logic             in_packet;
  logic             err_credit;
  logic             err_frame;

  flit_link_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .link_valid (link_valid),
    .link_flit  (link_flit),
    .credit_in  (credit_in),
    .credits    (credits),
    .in_packet  (in_packet),
    .err_credit (err_credit),
    .err_frame  (err_frame)
  );

  // Clock: rising edges at 5, 15, 25 ...; inputs change on falling edges
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  int               m_credits;
  bit               m_in_pkt;
  bit               m_err_credit;
  bit               m_err_frame;
  bit               m_valid;
  logic [WIDTH-1:0] m_flit;
  bit               hide = 1'b0;
  logic             last_read;

  typedef struct {
    bit               c;
    logic             exp_read;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_flit;
    int               exp_credits;
    bit               exp_in_pkt;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits    = CREDITS;
    m_in_pkt     = 1'b0;
    m_err_credit = 1'b0;
    m_err_frame  = 1'b0;
    m_valid      = 1'b0;
    m_flit       = '0;
    exp_q.delete();
  endtask

  // One clock cycle starting at a falling edge; ends at the next falling edge
  task automatic step(input bit c);
    bit               snd;
    logic [WIDTH-1:0] head;
    logic [1:0]       t;
    int               n;
    credit_in  = c;
    fifo_empty = hide || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    snd       = !fifo_empty && (m_credits != 0);
    last_read = fifo_read;
    check("fifo_read", fifo_read, snd);
    head = fifo_data;
    @(posedge clk);
    if (fifo_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (snd) begin
      t = head[WIDTH-1 -: 2];
      exp_q.push_back(head);
      m_flit = head;
      // Head/single must start a packet; body/tail must continue one
      if ((t == T_HEAD || t == T_SINGLE) == m_in_pkt) m_err_frame = 1'b1;
      if (t == T_HEAD)      m_in_pkt = 1'b1;
      else if (t != T_BODY) m_in_pkt = 1'b0;
    end
    m_valid = snd;
    n = m_credits - int'(snd) + int'(c);
    if (n > CREDITS) begin
      n = CREDITS;
      m_err_credit = 1'b1;
    end
    m_credits = n;
    #1;
    check("link_valid", link_valid, m_valid);
    check("link_flit", link_flit, m_flit);
    check("credits", credits, m_credits);
    check("in_packet", in_packet, m_in_pkt);
    check("err_credit", err_credit, m_err_credit);
    check("err_frame", err_frame, m_err_frame);
    if (link_valid) begin
      if (exp_q.size() == 0) check("sb_extra_flit", 1, 0);
      else                   check("sb_flit", link_flit, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // Async reset pulse of 5 ns placed between edges; outputs checked before any edge
  task automatic reset_pulse();
    fifo_empty = fifo_q.size() == 0;
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #2 rst = 1'b1;
    #1;
    check("rst_credits", credits, CREDITS);
    check("rst_link_valid", link_valid, 0);
    check("rst_link_flit", link_flit, 0);
    check("rst_in_packet", in_packet, 0);
    check("rst_err_credit", err_credit, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_fifo_read", fifo_read, 0);
    #4 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset, then a reset pulse with a non-empty FIFO
    repeat (2) step(1'b0);
    fifo_q.push_back(18'h30000);
    reset_pulse();
    fifo_q.delete();

    // 2: single packet, table driven
    tbl[0] = '{1'b0, 1'b1, 1'b1, 18'h10A5A, 3, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 18'h01234, 2, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 18'h2BEEF, 1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 18'h2BEEF, 1, 1'b0};
    fifo_q.push_back(18'h10A5A);
    fifo_q.push_back(18'h01234);
    fifo_q.push_back(18'h2BEEF);
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].c);
      check("t2_read", last_read, tbl[i].exp_read);
      check("t2_valid", link_valid, tbl[i].exp_valid);
      check("t2_flit", link_flit, tbl[i].exp_flit);
      check("t2_credits", credits, tbl[i].exp_credits);
      check("t2_in_packet", in_packet, tbl[i].exp_in_pkt);
    end
    repeat (3) step(1'b1);
    check("t2_credits_back", credits, 4);

    // 3: credit stall
    fifo_q.push_back(18'h10000);
    for (int i = 1; i <= 6; i++) fifo_q.push_back(WIDTH'(i));
    repeat (4) step(1'b0);
    check("t3_credits_zero", credits, 0);
    step(1'b0);
    check("t3_stall_read", last_read, 0);
    check("t3_stall_valid", link_valid, 0);
    step(1'b1);
    check("t3_credit_no_send", last_read, 0);
    check("t3_credit_one", credits, 1);
    step(1'b0);
    check("t3_resume_read", last_read, 1);
    check("t3_resume_flit", link_flit, 18'h00004);
    hide = 1'b1;
    step(1'b1);
    step(1'b1);
    hide = 1'b0;
    check("t3_credits_two", credits, 2);
    step(1'b1);
    check("t3_both_read", last_read, 1);
    check("t3_both_credits", credits, 2);
    check("t3_both_flit", link_flit, 18'h00005);
    step(1'b0);
    fifo_q.push_back(18'h2000F);
    step(1'b0);
    check("t3_tail_in_packet", in_packet, 0);
    check("t3_no_err_frame", err_frame, 0);
    repeat (4) step(1'b1);
    check("t3_credits_full", credits, 4);
    check("t3_no_err_credit", err_credit, 0);

    // 4: credit overflow
    step(1'b1);
    check("t4_err_credit", err_credit, 1);
    check("t4_credits_sat", credits, 4);
    repeat (3) step(1'b0);
    check("t4_err_sticky", err_credit, 1);

    // 5: framing errors
    fifo_q.push_back(18'h00001);
    step(1'b0);
    check("t5_body_forwarded", link_flit, 18'h00001);
    check("t5_body_err", err_frame, 1);
    fifo_q.push_back(18'h10000);
    fifo_q.push_back(18'h300FF);
    step(1'b0);
    step(1'b0);
    check("t5_single_flit", link_flit, 18'h300FF);
    check("t5_single_idle", in_packet, 0);
    check("t5_err_sticky", err_frame, 1);
    repeat (3) step(1'b1);

    // 6: reset mid-packet
    fifo_q.push_back(18'h11111);
    fifo_q.push_back(18'h02222);
    step(1'b0);
    step(1'b0);
    check("t6_in_packet", in_packet, 1);
    reset_pulse();
    fifo_q.delete();
    fifo_q.push_back(18'h15555);
    step(1'b0);
    check("t6_head_valid", link_valid, 1);
    check("t6_head_flit", link_flit, 18'h15555);
    check("t6_no_err_frame", err_frame, 0);
    check("t6_in_packet_again", in_packet, 1);

    // Random traffic against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit c;
      if (fifo_q.size() < 5 && $urandom_range(0, 2) != 0) begin
        fifo_q.push_back(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
      end
      hide = ($urandom_range(0, 9) == 0);
      c = ((CREDITS - m_credits) > 0 && $urandom_range(0, 1) == 1) ||
          ($urandom_range(0, 63) == 0);
      step(c);
    end
    hide = 1'b0;
    for (int cyc = 0; cyc < 60 && fifo_q.size() != 0; cyc++) begin
      step(m_credits < CREDITS);
    end
    check("drain_fifo_empty", fifo_q.size(), 0);
    step(1'b0);
    check("sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
